ps2_mouse_rx_ctrl: RTL and testbench

//  Sequences PS/2 mouse reception: debounces ps2_clk, detects falling edges, shifts 11-bit frames,

---
 rtl/ps2_mouse_rx_ctrl_pkg.sv | 26 ++
 rtl/ps2_clk_edge_filter.sv | 33 +++
 rtl/ps2_mouse_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ps2_mouse_rx_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_rx_ctrl_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
// The FSM state encoding and the movement-packet byte0 field positions live here.
package ps2_mouse_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int FRAME_BITS = 10;   // d0..d7, parity, stop (start is consumed in IDLE)
    localparam int PKT_BYTES  = 3;

    localparam int B0_BTN_MSB = 2;
    localparam int B0_SYNC    = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    // sr holds {stop, parity, d7..d0}; odd parity over data plus parity bit
    function automatic logic frame_ok(input logic [9:0] sr);
        return (^sr[8:0]) && sr[9];
    endfunction

endpackage

// File: rtl/ps2_clk_edge_filter.sv
// Synchronises the raw PS/2 clock, requires FILT_LEN equal samples before the
// filtered level changes, and emits a one-cycle strobe on its falling transition.
module ps2_clk_edge_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] hist;
    logic                level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], ps2_clk};
            hist <= {hist[FILT_LEN-2:0], sync[1]};
            if (&hist)
                level <= 1'b1;
            else if (hist == '0)
                level <= 1'b0;
            fall <= level && (hist == '0);
        end
    end

endmodule

// File: rtl/ps2_mouse_rx_ctrl.sv
// PS/2 mouse receiver: frame FSM, byte alignment, 3-byte packet assembly,
// valid/ready output stage and an inactivity watchdog.
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with data low)
// SHIFT  | sampling d0..d7, parity, stop on each fall
// CHECK  | one cycle: validate frame, store byte or flag error
module ps2_mouse_rx_ctrl
    import ps2_mouse_rx_ctrl_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       en,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [2:0] pkt_btn,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf,
    output logic       frame_err,
    output logic       pkt_drop,
    output logic       busy
);

    state_t            state, state_nxt;
    logic              clk_fall;
    logic [1:0]        data_sync;
    logic              data_s;
    logic [3:0]        bit_cnt;
    logic [9:0]        sr;
    logic [1:0]        byte_idx;
    logic [7:0]        byte0, byte1;
    logic [TO_W-1:0]   wd_cnt;
    logic              timeout;
    logic              start_frame, shift_en, chk_pass, chk_fail;
    logic              err_nxt, load_pkt;

    ps2_clk_edge_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .fall    (clk_fall)
    );

    assign data_s  = data_sync[1];
    assign busy    = (state != ST_IDLE) || (byte_idx != 2'd0);
    // a fall in the expiry cycle counts as activity, so it wins over the watchdog
    assign timeout = busy && (wd_cnt == '0) && !clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        chk_pass    = 1'b0;
        chk_fail    = 1'b0;
        if (!en || timeout) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clk_fall && !data_s) begin
                        state_nxt   = ST_SHIFT;
                        start_frame = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (clk_fall) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 4'(FRAME_BITS - 1))
                            state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_nxt = ST_IDLE;
                    if (frame_ok(sr))
                        chk_pass = 1'b1;
                    else
                        chk_fail = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        err_nxt  = chk_fail || (en && timeout && (state != ST_IDLE));
        load_pkt = chk_pass && (byte_idx == 2'(PKT_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            byte_idx  <= '0;
            byte0     <= '0;
            byte1     <= '0;
            wd_cnt    <= TO_W'(TIMEOUT_CYC);
            frame_err <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_drop  <= 1'b0;
            pkt_btn   <= '0;
            pkt_dx    <= '0;
            pkt_dy    <= '0;
            pkt_ovf   <= '0;
        end else begin
            data_sync <= {data_sync[0], ps2_data};
            frame_err <= err_nxt;

            if (start_frame)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 4'd1;

            if (shift_en)
                sr <= {data_s, sr[9:1]};

            if (clk_fall)
                wd_cnt <= TO_W'(TIMEOUT_CYC);
            else if (busy && (wd_cnt != '0))
                wd_cnt <= wd_cnt - 1'b1;

            if (!en || timeout || chk_fail) begin
                byte_idx <= '0;
            end else if (chk_pass) begin
                case (byte_idx)
                    2'd0: begin
                        // byte0 always carries bit3 set; anything else is misaligned
                        if (sr[B0_SYNC]) begin
                            byte0    <= sr[7:0];
                            byte_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1    <= sr[7:0];
                        byte_idx <= 2'd2;
                    end
                    default: byte_idx <= '0;
                endcase
            end

            if (load_pkt && (!pkt_valid || pkt_ready)) begin
                pkt_valid <= 1'b1;
                pkt_btn   <= byte0[B0_BTN_MSB:0];
                pkt_dx    <= {byte0[B0_XSIGN], byte1};
                pkt_dy    <= {byte0[B0_YSIGN], sr[7:0]};
                pkt_ovf   <= {byte0[B0_YOVF], byte0[B0_XOVF]};
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end

            if (!en)
                pkt_drop <= 1'b0;
            else if (load_pkt && pkt_valid && !pkt_ready)
                pkt_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx_ctrl.sv
// Bench for ps2_mouse_rx_ctrl: PS/2 frames are driven bit by bit, a byte-level
// packet model fills a scoreboard and a monitor checks every delivered packet.
module tb_ps2_mouse_rx_ctrl;

    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int TO_W        = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       en = 1'b0;
    logic       pkt_ready = 1'b0;
    logic       pkt_valid;
    logic [2:0] pkt_btn;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [1:0] pkt_ovf;
    logic       frame_err;
    logic       pkt_drop;
    logic       busy;

    always #5 clk = ~clk;

    ps2_mouse_rx_ctrl #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .en        (en),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_btn   (pkt_btn),
        .pkt_dx    (pkt_dx),
        .pkt_dy    (pkt_dy),
        .pkt_ovf   (pkt_ovf),
        .frame_err (frame_err),
        .pkt_drop  (pkt_drop),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_exp = 0;
    int err_seen = 0;
    int fall_seen = 0;
    int last_fall = -100;
    bit drop_exp = 1'b0;

    // expected packet packed as {ovf[1:0], btn[2:0], dx[8:0], dy[8:0]}
    logic [22:0] sb[$];
    logic [7:0]  mb0, mb1;
    int          midx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: one received byte at a time, in protocol terms.
    task automatic model_byte(input logic [7:0] b, input bit good);
        logic [22:0] p;
        if (!good) begin
            err_exp++;
            midx = 0;
        end else if (midx == 0) begin
            if (b[3]) begin
                mb0  = b;
                midx = 1;
            end
        end else if (midx == 1) begin
            mb1  = b;
            midx = 2;
        end else begin
            midx = 0;
            p = {mb0[7], mb0[6], mb0[2:0], mb0[4], mb1, mb0[5], b};
            if (!pkt_ready && sb.size() > 0)
                drop_exp = 1'b1;
            else
                sb.push_back(p);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cyc(12);
            ps2_clk = 1'b0;
            wait_cyc(25);
            ps2_clk = 1'b1;
            wait_cyc(13);
        end
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_byte(b, !(bad_par || bad_stop));
        ps2_bits(make_frame(b, bad_par, bad_stop), 11);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
    endtask

    task automatic settle(input string tag);
        wait_cyc(20);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_frame_err_count"}, 32'(err_seen), 32'(err_exp));
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: scoreboard pop on handshake, latency and hold-stability checks.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [22:0] prev_fields = '0;
    always @(negedge clk) begin
        logic [22:0] cur;
        logic [22:0] exp;
        cur = {pkt_ovf, pkt_btn, pkt_dx, pkt_dy};
        if (rst_n) begin
            if (dut.clk_fall) begin
                fall_seen++;
                last_fall = cyc;
            end
            if (frame_err) err_seen++;
            if (pkt_valid && !prev_valid)
                chk("valid_latency", 32'(cyc - last_fall), 32'd2);
            if (pkt_valid && prev_valid && !prev_ready)
                chk("hold_stable", {9'd0, cur}, {9'd0, prev_fields});
            if (pkt_valid && pkt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt: got %h expected none", cur);
                end else begin
                    exp = sb.pop_front();
                    chk("pkt_fields", {9'd0, cur}, {9'd0, exp});
                end
            end
        end
        prev_valid  = pkt_valid;
        prev_ready  = pkt_ready;
        prev_fields = cur;
    end

    initial begin
        int f0;
        int c;
        logic [7:0] rb;

        wait_cyc(4);
        chk("reset_outputs", {18'd0, pkt_valid, frame_err, pkt_drop, busy, pkt_btn, pkt_dx[0], pkt_ovf},
            32'd0);
        chk("reset_fields", {14'd0, pkt_dx, pkt_dy}, 32'd0);
        rst_n = 1'b1;
        en = 1'b1;
        pkt_ready = 1'b1;
        wait_cyc(40);

        // basic packet
        send_pkt(8'h09, 8'h05, 8'hFB);
        settle("t1");

        // parity error on byte1, then a clean packet
        send_byte(8'h18, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        chk("t2_err_seen", 32'(err_seen), 32'(err_exp));
        send_pkt(8'h0A, 8'h10, 8'h20);
        settle("t2");

        // misaligned first byte dropped silently
        send_byte(8'h05, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h01, 8'h02);
        settle("t3");

        // mid-frame timeout, then idle timeout with a partial packet
        ps2_bits(make_frame(8'h3C, 1'b0, 1'b0), 5);
        chk("t4_busy_mid", {31'd0, busy}, 32'd1);
        wait_cyc(TIMEOUT_CYC + 50);
        err_exp++;
        midx = 0;
        settle("t4a");
        send_pkt(8'h29, 8'h80, 8'h7F);
        settle("t4b");
        send_byte(8'h08, 1'b0, 1'b0);
        chk("t4_busy_idx", {31'd0, busy}, 32'd1);
        wait_cyc(TIMEOUT_CYC + 50);
        midx = 0;
        settle("t4c");
        send_pkt(8'hC8, 8'hFF, 8'h00);
        settle("t4d");

        // backpressure across two packets
        pkt_ready = 1'b0;
        send_pkt(8'h1B, 8'h33, 8'h44);
        send_pkt(8'h2C, 8'h55, 8'h66);
        wait_cyc(20);
        chk("t5_valid_held", {31'd0, pkt_valid}, 32'd1);
        chk("t5_drop", {31'd0, pkt_drop}, {31'd0, drop_exp});
        pkt_ready = 1'b1;
        wait_cyc(3);
        chk("t5_valid_fell", {31'd0, pkt_valid}, 32'd0);
        en = 1'b0;
        wait_cyc(2);
        chk("t5_drop_clr", {31'd0, pkt_drop}, 32'd0);
        en = 1'b1;
        drop_exp = 1'b0;
        settle("t5");

        // short glitches produce no edges
        f0 = fall_seen;
        for (int i = 0; i < 12; i++) begin
            ps2_clk = 1'b0;
            wait_cyc($urandom_range(1, 3));
            ps2_clk = 1'b1;
            wait_cyc(15);
        end
        chk("t6_no_fall", 32'(fall_seen - f0), 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);

        // reset mid-frame with a packet pending
        pkt_ready = 1'b0;
        send_pkt(8'h0F, 8'h11, 8'h22);
        ps2_bits(make_frame(8'h55, 1'b0, 1'b0), 4);
        chk("t6_pending", {30'd0, pkt_valid, busy}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {28'd0, pkt_valid, frame_err, pkt_drop, busy}, 32'd0);
        chk("t6_rst_fields", {9'd0, pkt_ovf, pkt_btn, pkt_dx, pkt_dy}, 32'd0);
        sb.delete();
        midx = 0;
        wait_cyc(3);
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        wait_cyc(40);
        settle("t6");

        // randomized byte stream with occasional misalignment and corrupt frames
        for (int i = 0; i < 36; i++) begin
            rb = 8'($urandom);
            if ((i % 3) == 0 && $urandom_range(0, 4) != 0) rb[3] = 1'b1;
            c = $urandom_range(0, 9);
            send_byte(rb, c == 0, c == 1);
        end
        wait_cyc(20);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_frame_err_count", 32'(err_seen), 32'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
